// File: rtl/serial_array_reader.sv
// Snapshots a flat array on start and streams it out one element per
// valid/ready handshake, reporting the element sum when the scan completes.
module serial_array_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5,
  parameter int SW    = WIDTH + $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DEPTH*WIDTH-1:0]   arr_in,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH)-1:0] out_index,
  output logic                     out_last,
  output logic                     done,
  output logic [SW-1:0]            sum_out
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                 state;
  logic [DEPTH*WIDTH-1:0] snapshot;
  logic [SW-1:0]          acc;
  logic [IW-1:0]          next_idx;
  logic [SW-1:0]          acc_next;
  logic                   handshake;

  assign next_idx  = out_index + 1'b1;
  assign acc_next  = acc + SW'(out_data);
  assign handshake = out_valid && out_ready;

  // out_data is preloaded from the snapshot so every output stays registered
  // and holds naturally while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      snapshot  <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      sum_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            snapshot  <= arr_in;
            acc       <= '0;
            out_index <= '0;
            out_data  <= arr_in[WIDTH-1:0];
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (handshake) begin
            acc <= acc_next;
            if (out_index == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              sum_out   <= acc_next;
              state     <= DONE;
            end else begin
              out_index <= next_idx;
              out_data  <= snapshot[int'(next_idx)*WIDTH +: WIDTH];
              out_last  <= (next_idx == LAST_IDX);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_array_reader.sv
// Randomized self-checking bench for serial_array_reader: each scan is compared
// against the captured array, its expected element order and its plain integer sum.
module tb_serial_array_reader;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int SW = W + $clog2(D);
  localparam int IW = $clog2(D);

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [D*W-1:0] arr_in;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_index;
  logic           out_last;
  logic           done;
  logic [SW-1:0]  sum_out;

  int tests;
  int fails;

  serial_array_reader #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .arr_in(arr_in), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .done(done), .sum_out(sum_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [D*W-1:0] makeRamp();
    logic [D*W-1:0] a;
    for (int i = 0; i < D; i++) a[i*W +: W] = W'(i);
    return a;
  endfunction

  function automatic logic [D*W-1:0] makeRandom();
    logic [D*W-1:0] a;
    for (int i = 0; i < D; i++) a[i*W +: W] = W'($urandom_range(0, 255));
    return a;
  endfunction

  // readyMode: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random
  task automatic applyStimulus(input logic [D*W-1:0] arr, input int readyMode,
                               input bit corrupt, input bit pokeStart);
    int elems[$];
    int expSum;
    int pos;
    int cycles;
    elems = {};
    expSum = 0;
    for (int i = 0; i < D; i++) begin
      elems.push_back(int'(arr[i*W +: W]));
      expSum += int'(arr[i*W +: W]);
    end
    @(negedge clk);
    checkOutput("idleDone", 32'(done), 0);
    checkOutput("idleBusy", 32'(busy), 0);
    checkOutput("idleValid", 32'(out_valid), 0);
    arr_in = arr;
    start = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    checkOutput("startValid", 32'(out_valid), 1);
    checkOutput("startIndex", 32'(out_index), 0);
    start = 1'b0;
    if (corrupt) arr_in = '0;
    pos = 0;
    cycles = 0;
    while (pos < D && cycles < 200) begin
      checkOutput("scanValid", 32'(out_valid), 1);
      checkOutput("scanData", 32'(out_data), 32'(elems[pos]));
      checkOutput("scanIndex", 32'(out_index), 32'(pos));
      checkOutput("scanLast", 32'(out_last), 32'(pos == D - 1));
      checkOutput("scanDone", 32'(done), 0);
      checkOutput("scanBusy", 32'(busy), 1);
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cycles % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      start = pokeStart ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (out_ready) pos++;
      cycles++;
    end
    if (cycles >= 200) checkOutput("scanTimeout", 0, 1);
    checkOutput("donePulse", 32'(done), 1);
    checkOutput("doneValid", 32'(out_valid), 0);
    checkOutput("doneLast", 32'(out_last), 0);
    checkOutput("doneSum", 32'(sum_out), 32'(expSum));
    start = 1'b0;
    out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic resetMidScan();
    int cycles;
    @(negedge clk);
    arr_in = makeRamp();
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (out_index != IW'(2) && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("reachIndex2", 32'(out_index), 2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstValid", 32'(out_valid), 0);
    checkOutput("rstIndex", 32'(out_index), 0);
    checkOutput("rstData", 32'(out_data), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstSum", 32'(sum_out), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rstNoDone", 32'(done), 0);
    end
    #1 rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    arr_in = '0;
    #3;
    checkOutput("resetBusy", 32'(busy), 0);
    checkOutput("resetValid", 32'(out_valid), 0);
    checkOutput("resetDone", 32'(done), 0);
    checkOutput("resetLast", 32'(out_last), 0);
    checkOutput("resetSum", 32'(sum_out), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(makeRamp(), 0, 1'b0, 1'b0);
    applyStimulus(makeRamp(), 1, 1'b0, 1'b0);
    applyStimulus({D{8'hFF}}, 2, 1'b0, 1'b0);
    applyStimulus(makeRamp(), 0, 1'b1, 1'b0);
    applyStimulus(makeRandom(), 2, 1'b0, 1'b1);
    applyStimulus(makeRandom(), 0, 1'b1, 1'b1);

    resetMidScan();
    applyStimulus(makeRamp(), 0, 1'b0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      applyStimulus(makeRandom(), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    checkOutput("finalDoneLow", 32'(done), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
